// File: rtl/alu_multiword_seq.sv
// alu_multiword_seq
// Sequencer that runs one WORDS*16-bit add/subtract through an external
// combinational 16-bit ALU. It feeds one slice per cycle, least significant
// slice first, and chains the carry through the ALU's c_pre input.
// The slice sums are assembled into a wide result, and whole-operand
// z/c/n/v flags are produced alongside it.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start            request, sampled only in IDLE or DONE
//   op, cin          ALU control for the whole operation; carry into slice 0
//   opa, opb         wide operands, latched when a start is accepted
//   busy, done       busy while slices run; done is a one-cycle result-valid pulse
//   result, z/c/n/v  wide sum and flags, held until the next accepted start
//   alu_a/b/ctrl/cpre  slice operands and control driven to the ALU
//   alu_s, alu_z/c/n/v slice sum and flags returned by the ALU
module alu_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic                cin,
  input  logic [16*WORDS-1:0] opa,
  input  logic [16*WORDS-1:0] opb,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] result,
  output logic                z,
  output logic                c,
  output logic                n,
  output logic                v,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output logic [1:0]          alu_ctrl,
  output logic                alu_cpre,
  input  logic [15:0]         alu_s,
  input  logic                alu_z,
  input  logic                alu_c,
  input  logic                alu_n,
  input  logic                alu_v
);

  localparam int W    = 16 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, next_state;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    a_lat, b_lat;
  logic [1:0]      op_lat;
  logic            carry;
  logic            zacc;
  logic            accept;
  logic            last;

  // A start only counts when no operation is in flight.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The ALU-facing outputs are muxed only from registered state, so there is
  // no combinational path from the ALU's outputs back into its inputs.
  // They idle at zero outside RUN.
  always_comb begin
    busy     = (state == RUN);
    done     = (state == DONE);
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    alu_cpre = 1'b0;
    if (state == RUN) begin
      alu_a    = a_lat[16*idx +: 16];
      alu_b    = b_lat[16*idx +: 16];
      alu_ctrl = op_lat;
      alu_cpre = carry;
    end
  end

  // Each RUN cycle captures one slice. The zero flag must cover every slice,
  // so it is accumulated, while c/n/v come only from the most significant slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      op_lat <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      result <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      n      <= 1'b0;
      v      <= 1'b0;
    end else if (accept) begin
      a_lat  <= opa;
      b_lat  <= opb;
      op_lat <= op;
      carry  <= cin;
      idx    <= '0;
      zacc   <= 1'b1;
    end else if (state == RUN) begin
      result[16*idx +: 16] <= alu_s;
      carry <= alu_c;
      zacc  <= zacc & alu_z;
      if (last) begin
        z <= zacc & alu_z;
        c <= alu_c;
        n <= alu_n;
        v <= alu_v;
      end else begin
        idx <= idx + IDX_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Testbench for alu_multiword_seq with WORDS=4.
// A behavioural 16-bit ALU closes the loop around the sequencer. Expected
// wide results come from a direct 64-bit arithmetic model. They are queued
// when stimulus is driven and compared when done pulses.
module tb_alu_multiword_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic          cin;
  logic [W-1:0]  opa, opb;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          z, c, n, v;
  logic [15:0]   alu_a, alu_b;
  logic [1:0]    alu_ctrl;
  logic          alu_cpre;
  logic [15:0]   alu_s;
  logic          alu_z, alu_c, alu_n, alu_v;

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, n, v;
    int           done_cycle;
  } exp_t;

  exp_t sb[$];
  int   cycle;
  int   n_checks;
  int   n_fail;

  alu_multiword_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
    .z(z), .c(c), .n(n), .v(v),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_cpre(alu_cpre),
    .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural combinational 16-bit ALU seen by the sequencer.
  logic [15:0] alu_bb;
  logic [16:0] alu_sum;
  always_comb begin
    alu_bb  = alu_ctrl[1] ? ~alu_b : alu_b;
    alu_sum = {1'b0, alu_a} + {1'b0, alu_bb} + {16'b0, alu_cpre};
    alu_s   = alu_sum[15:0];
    alu_c   = alu_sum[16];
    alu_n   = alu_sum[15];
    alu_z   = (alu_sum[15:0] == 16'h0);
    alu_v   = (alu_a[15] == alu_bb[15]) && (alu_sum[15] != alu_a[15]);
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic ci,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb = o[1] ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
    e.res = s[W-1:0];
    e.c   = s[W];
    e.n   = s[W-1];
    e.z   = (s[W-1:0] == '0);
    e.v   = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    e.done_cycle = 0;
    return e;
  endfunction

  // Drives a one-cycle start at a falling edge and queues the expected result.
  // Returns at the next falling edge, when slice 0 is on the ALU.
  task automatic applyStimulus(input logic [1:0] o, input logic ci,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    op = o; cin = ci; opa = a; opb = b; start = 1'b1;
    e = model(o, ci, a, b);
    e.done_cycle = cycle + 1 + WORDS;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("drain", W'(sb.size()), W'(0));
  endtask

  // Scoreboard: every done pulse must match the oldest queued operation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", W'(1), W'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("z", W'(z), W'(e.z));
        checkOutput("c", W'(c), W'(e.c));
        checkOutput("n", W'(n), W'(e.n));
        checkOutput("v", W'(v), W'(e.v));
        checkOutput("done_cycle", W'(cycle), W'(e.done_cycle));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    n_checks = 0; n_fail = 0; cycle = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; cin = 1'b0; opa = '0; opb = '0;
    #12;
    checkOutput("rst_busy", W'(busy), W'(0));
    checkOutput("rst_done", W'(done), W'(0));
    checkOutput("rst_result", result, W'(0));
    checkOutput("rst_flags", W'({z, c, n, v}), W'(0));
    checkOutput("rst_alu", W'({alu_a, alu_b, alu_ctrl, alu_cpre}), W'(0));
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] case 1: carry across slice boundary");
    applyStimulus(2'b00, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
    checkOutput("busy_run", W'(busy), W'(1));
    waitDrain();

    $display("[TB] case 2: full-width wrap to zero");
    applyStimulus(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    waitDrain();

    $display("[TB] case 3: subtract with cin");
    applyStimulus(2'b10, 1'b1, 64'h5, 64'h7);
    checkOutput("slice0_cpre", W'(alu_cpre), W'(1));
    checkOutput("slice0_ctrl", W'(alu_ctrl), W'(2));
    checkOutput("slice0_a", W'(alu_a), W'(16'h0005));
    checkOutput("slice0_b", W'(alu_b), W'(16'h0007));
    waitDrain();

    $display("[TB] case 4: signed overflow");
    applyStimulus(2'b01, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    waitDrain();
    checkOutput("idle_busy", W'(busy), W'(0));

    $display("[TB] case 5: start while busy is ignored");
    applyStimulus(2'b00, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
    @(negedge clk);
    op = 2'b10; cin = 1'b1; opa = 64'h1234; opb = 64'h9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain();

    $display("[TB] case 5b: reset mid-operation");
    applyStimulus(2'b00, 1'b0, 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", W'(busy), W'(0));
    checkOutput("midrst_done", W'(done), W'(0));
    checkOutput("midrst_result", result, W'(0));
    checkOutput("midrst_flags", W'({z, c, n, v}), W'(0));
    checkOutput("midrst_alu", W'({alu_a, alu_b, alu_ctrl, alu_cpre}), W'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("post_rst_result", result, W'(0));

    $display("[TB] case 6: start held through DONE");
    @(negedge clk);
    op = 2'b00; cin = 1'b0; opa = 64'h0000_0000_0000_FFFF; opb = 64'h1; start = 1'b1;
    e = model(2'b00, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
    e.done_cycle = cycle + 1 + WORDS;
    sb.push_back(e);
    @(negedge clk);
    op = 2'b10; cin = 1'b1; opa = 64'h0000_0001_0000_0000; opb = 64'h3;
    e = model(2'b10, 1'b1, 64'h0000_0001_0000_0000, 64'h3);
    e.done_cycle = sb[0].done_cycle + 1 + WORDS;
    sb.push_back(e);
    repeat (5) @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_busy", W'(busy), W'(1));
    waitDrain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
